// File: rtl/stb_pkg.sv
// Shared types for the store buffer: drain FSM states and the buffered store entry.
// Entry fields are sized for the widest supported build; narrower ADDR_W/DATA_W zero-pad.
package stb_pkg;

    localparam int unsigned STB_ADDR_W = 32;
    localparam int unsigned STB_DATA_W = 32;
    localparam int unsigned STB_SEL_W  = STB_DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [STB_ADDR_W-1:0] addr;
        logic [STB_DATA_W-1:0] wdata;
        logic [STB_SEL_W-1:0]  sel_byte;
    } stb_entry_t;

endpackage

// File: rtl/stb_queue_if.sv
// Cache drain port of the store buffer: one write request held until acknowledged.
interface stb_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    localparam int unsigned SEL_W = DATA_W / 8;

    logic              cache_req_o;
    logic [ADDR_W-1:0] cache_addr_o;
    logic [DATA_W-1:0] cache_wdata_o;
    logic [SEL_W-1:0]  cache_sel_byte_o;
    logic              cache_ack_i;

    modport master (
        output cache_req_o,
        output cache_addr_o,
        output cache_wdata_o,
        output cache_sel_byte_o,
        input  cache_ack_i
    );

    modport slave (
        input  cache_req_o,
        input  cache_addr_o,
        input  cache_wdata_o,
        input  cache_sel_byte_o,
        output cache_ack_i
    );

endinterface

// File: rtl/stb_fifo.sv
// Circular store-entry storage with per-slot valid bits, head view and occupancy count.
// With STB_LOAD_FWD_EN defined, all slots, valid bits and the read pointer are exported.
module stb_fifo
    import stb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  stb_entry_t           entry_i,
    input  logic                 pop_i,
    output stb_entry_t           head_o,
    output logic [CNT_W-1:0]     count_o
`ifdef STB_LOAD_FWD_EN
    ,
    output stb_entry_t [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [PTR_W-1:0]       rd_ptr_o
`endif
);

    stb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (pop_i) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: nothing reads a slot before its valid bit is set.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

`ifdef STB_LOAD_FWD_EN
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;
`endif

endmodule

// File: rtl/stb_queue.sv
// Store buffer: accepts LSU stores, drains them in order to the cache, optional load forwarding.
// Define STB_LOAD_FWD_EN to enable forwarding; ADDR_W/DATA_W must not exceed the stb_pkg widths.
module stb_queue
    import stb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned SEL_W = DATA_W / 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_sel_i,
    input  logic              lsu_req_i,
    input  logic              lsu_w_en_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [SEL_W-1:0]  lsu_sel_byte_i,
    output logic              stb_ack_o,
    output logic              stb_stall_o,
    stb_queue_if.master       cache,
    output logic              stb_empty_o,
    output logic              stb_full_o,
    output logic [CNT_W-1:0]  stb_count_o,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_hit_o,
    output logic              ld_partial_o,
    output logic [DATA_W-1:0] ld_data_o
);

    drain_state_e     state_q, state_d;
    logic             ack_q, ack_d;
    logic             store_qual, push, pop;
    logic [CNT_W-1:0] count;
    stb_entry_t       entry_in, head;

    assign store_qual  = dmem_sel_i & lsu_req_i & lsu_w_en_i;
    assign push        = store_qual & ~stb_full_o;
    assign stb_stall_o = store_qual & stb_full_o;
    assign ack_d       = push;

    always_comb begin
        entry_in                       = '0;
        entry_in.addr[ADDR_W-1:0]      = lsu_addr_i;
        entry_in.wdata[DATA_W-1:0]     = lsu_wdata_i;
        entry_in.sel_byte[SEL_W-1:0]   = lsu_sel_byte_i;
    end

`ifdef STB_LOAD_FWD_EN
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = $clog2(SEL_W);

    stb_entry_t [DEPTH-1:0] fwd_entries;
    logic [DEPTH-1:0]       fwd_valid;
    logic [PTR_W-1:0]       fwd_rd_ptr;
    logic [PTR_W-1:0]       fwd_idx;
`endif

    stb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .entry_i   (entry_in),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count)
`ifdef STB_LOAD_FWD_EN
        ,
        .entries_o (fwd_entries),
        .valid_o   (fwd_valid),
        .rd_ptr_o  (fwd_rd_ptr)
`endif
    );

    assign stb_count_o = count;
    assign stb_full_o  = (count == CNT_W'(DEPTH));
    assign stb_empty_o = (count == '0);

    // IDLE only ever holds an empty buffer, so a push leaves IDLE in the same edge it lands.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (push || !stb_empty_o) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pop = cache.cache_ack_i;
                if (cache.cache_ack_i && count == CNT_W'(1) && !push) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    assign stb_ack_o              = ack_q;
    assign cache.cache_req_o      = (state_q == DRAIN);
    assign cache.cache_addr_o     = cache.cache_req_o ? head.addr[ADDR_W-1:0]      : '0;
    assign cache.cache_wdata_o    = cache.cache_req_o ? head.wdata[DATA_W-1:0]     : '0;
    assign cache.cache_sel_byte_o = cache.cache_req_o ? head.sel_byte[SEL_W-1:0]   : '0;

`ifdef STB_LOAD_FWD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        ld_hit_o     = 1'b0;
        ld_partial_o = 1'b0;
        ld_data_o    = '0;
        fwd_idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = fwd_rd_ptr + PTR_W'(k);
            if (fwd_valid[fwd_idx] &&
                fwd_entries[fwd_idx].addr[ADDR_W-1:OFF_W] == ld_addr_i[ADDR_W-1:OFF_W]) begin
                ld_hit_o     = 1'b1;
                ld_data_o    = fwd_entries[fwd_idx].wdata[DATA_W-1:0];
                ld_partial_o = (fwd_entries[fwd_idx].sel_byte[SEL_W-1:0] != '1);
            end
        end
    end
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr_i;
    assign ld_hit_o       = 1'b0;
    assign ld_partial_o   = 1'b0;
    assign ld_data_o      = '0;
`endif

endmodule
